// File: rtl/button_in_pio_if.sv
// Avalon-MM slave bus bundle for the pushbutton/switch input PIO.
// Master drives address/strobes/writedata; slave returns combinational readdata.
interface button_in_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/button_in_pio.sv
// Input PIO: 2-flop sync + per-bit debounce; level visible 2+DEBOUNCE_CYCLES edges after input change.
// Sticky edge capture with W1C and IRQ mask; zero-wait-state reads, no backpressure.
module button_in_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  button_in_pio_if.slave        bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] change, qual, clr;
  logic             wr_en;
  logic             wd_unused;

  assign wd_unused = ^bus.writedata;
  assign wr_en     = bus.chipselect && !bus.write_n;

  always_comb begin
    stable_d = stable_q;
    change   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          change[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    qual = '0;
    case (EDGE_TYPE)
      0:       qual = change & stable_d;
      1:       qual = change & ~stable_d;
      default: qual = change;
    endcase
  end

  // A capture in the same cycle as a W1C clear of that bit must survive.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
    cap_d = (cap_q & ~clr) | qual;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_VALUE;
      sync2_q  <= RESET_VALUE;
      stable_q <= RESET_VALUE;
      mask_q   <= '0;
      cap_q    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = stable_q;
      2'd2:    bus.readdata[WIDTH-1:0] = mask_q;
      2'd3:    bus.readdata[WIDTH-1:0] = cap_q;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_in_pio.sv
// Directed bench for button_in_pio with WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_button_in_pio;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  int         vectors = 0;
  int         miscompares = 0;

  button_in_pio_if bus ();

  button_in_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus.address = addr;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  initial begin
    reset = 1'b1;
    in_port = 4'hF;
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    repeat (3) tick();
    reset = 1'b0;
    rd(2'd0, 32'hF, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_cap");
    chk_irq(1'b0, "rst_irq");

    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "rsvd_wr_ignored");
    wr(2'd2, 32'hFFFF_FFF1);
    rd(2'd2, 32'h1, "mask_wr");

    // Falling edge on bit 0: invisible through E+4, visible after E+5.
    in_port = 4'hE;
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(2'd0, 32'hF, "deb_hold");
    end
    tick();
    rd(2'd0, 32'hE, "deb_data");
    rd(2'd3, 32'h1, "fall_cap");
    chk_irq(1'b1, "fall_irq");
    wr(2'd3, 32'h1);
    chk_irq(1'b0, "w1c_irq_drop");
    rd(2'd3, 32'h0, "w1c_cap_zero");

    // Three-clock glitch on bit 1 must not be accepted.
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (8) tick();
    rd(2'd0, 32'hE, "glitch_data");
    rd(2'd3, 32'h0, "glitch_cap");
    chk_irq(1'b0, "glitch_irq");

    // Rising edges are not captured with falling-edge selection.
    in_port = 4'hF;
    repeat (6) tick();
    rd(2'd0, 32'hF, "rise_data");
    rd(2'd3, 32'h0, "rise_nocap");

    in_port = 4'hC;
    repeat (6) tick();
    rd(2'd0, 32'hC, "two_fall_data");
    rd(2'd3, 32'h3, "two_fall_cap");
    chk_irq(1'b1, "two_fall_irq");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, "w1c_partial");
    chk_irq(1'b0, "w1c_partial_irq");

    // Bit 2 debounces on the same edge that writes 1 to clear it.
    in_port = 4'h8;
    repeat (5) tick();
    wr(2'd3, 32'h4);
    rd(2'd0, 32'h8, "coll_data");
    rd(2'd3, 32'h6, "coll_set_wins");

    wr(2'd2, 32'h0);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h2, "gate_cap");
    chk_irq(1'b0, "gate_masked");
    wr(2'd2, 32'h2);
    chk_irq(1'b1, "gate_unmasked");
    wr(2'd3, 32'h2);
    chk_irq(1'b0, "gate_cleared");
    rd(2'd3, 32'h0, "gate_cap_zero");

    // Reset in the middle of a debounce discards the count.
    in_port = 4'hF;
    repeat (6) tick();
    rd(2'd0, 32'hF, "pre_rst_data");
    in_port = 4'hE;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rd(2'd0, 32'hF, "mid_rst_data");
    rd(2'd3, 32'h0, "mid_rst_cap");
    rd(2'd2, 32'h0, "mid_rst_mask");
    chk_irq(1'b0, "mid_rst_irq");
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(2'd0, 32'hF, "post_rst_hold");
    end
    tick();
    rd(2'd0, 32'hE, "post_rst_data");
    rd(2'd3, 32'h1, "post_rst_cap");
    chk_irq(1'b0, "post_rst_irq_masked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
